// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit:
// state encodings, opcodes, ALUOp codes, mux selects and the control bundle.
package controle_multiciclo_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11,
        S_ILLEGAL  = 4'd12
    } estado_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_FUNCT = 4'd2;
    localparam logic [3:0] ALU_ADDI  = 4'd3;
    localparam logic [3:0] ALU_SLTI  = 4'd4;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       excecao;
    } ctrl_t;

endpackage

// File: rtl/controle_multiciclo_saidas.sv
// Moore output decode: state (and latched opcode) to datapath control lines.
// Optional macro WAIT_STATE_EN gates the FETCH register writes with mem_ready_i.
module controle_saidas
    import controle_multiciclo_pkg::*;
(
    input  logic       rst_i,
    input  estado_t    estado_i,
    input  logic [5:0] op_i,
`ifdef WAIT_STATE_EN
    input  logic       mem_ready_i,
`endif
    output ctrl_t      ctrl_o,
    output logic [3:0] estado_o
);

    logic fetch_done;

`ifdef WAIT_STATE_EN
    assign fetch_done = mem_ready_i;
`else
    assign fetch_done = 1'b1;
`endif

    // Per-state control decode; reset forces every output low.
    always_comb begin
        ctrl_o   = '0;
        estado_o = estado_i;
        case (estado_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = fetch_done;
                ctrl_o.pc_write  = fetch_done;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCS_ALU;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_source     = PCS_ALUOUT;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.branch_ne     = (op_i == OP_BNE);
            end
            S_JUMP: begin
                ctrl_o.pc_source = PCS_JUMP;
                ctrl_o.pc_write  = 1'b1;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (op_i == OP_SLTI) ? ALU_SLTI : ALU_ADDI;
            end
            S_I_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_ILLEGAL: begin
                ctrl_o.excecao = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
        if (rst_i) begin
            ctrl_o   = '0;
            estado_o = '0;
        end
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS control FSM: state register, latched opcode, next-state logic.
// Optional macro WAIT_STATE_EN stretches FETCH/MEM_RD/MEM_WR until MemReady.
module controle_multiciclo
    import controle_multiciclo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       Excecao,
    output logic [3:0] Estado
);

    estado_t    estado_q, estado_d;
    logic [5:0] op_q, op_d;
    logic       mem_ok;
    ctrl_t      ctrl;

`ifdef WAIT_STATE_EN
    assign mem_ok = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_ok = 1'b1;
`endif

    // State and latched-opcode registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= S_FETCH;
            op_q     <= '0;
        end else begin
            estado_q <= estado_d;
            op_q     <= op_d;
        end
    end

    // Next-state logic; opcode is captured on leaving DECODE.
    always_comb begin
        estado_d = estado_q;
        op_d     = op_q;
        case (estado_q)
            S_FETCH:    if (mem_ok) estado_d = S_DECODE;
            S_DECODE: begin
                op_d = OpCode;
                case (OpCode)
                    OP_LW, OP_SW:     estado_d = S_MEM_ADDR;
                    OP_R:             estado_d = S_EXEC_R;
                    OP_BEQ, OP_BNE:   estado_d = S_BRANCH;
                    OP_J:             estado_d = S_JUMP;
                    OP_ADDI, OP_SLTI: estado_d = S_EXEC_I;
                    default:          estado_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: estado_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ok) estado_d = S_MEM_WB;
            S_MEM_WB:   estado_d = S_FETCH;
            S_MEM_WR:   if (mem_ok) estado_d = S_FETCH;
            S_EXEC_R:   estado_d = S_R_WB;
            S_R_WB:     estado_d = S_FETCH;
            S_BRANCH:   estado_d = S_FETCH;
            S_JUMP:     estado_d = S_FETCH;
            S_EXEC_I:   estado_d = S_I_WB;
            S_I_WB:     estado_d = S_FETCH;
            S_ILLEGAL:  estado_d = S_ILLEGAL;
            default:    estado_d = S_FETCH;
        endcase
    end

    controle_saidas u_saidas (
        .rst_i       (reset),
        .estado_i    (estado_q),
        .op_i        (op_q),
`ifdef WAIT_STATE_EN
        .mem_ready_i (MemReady),
`endif
        .ctrl_o      (ctrl),
        .estado_o    (Estado)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign BranchNE    = ctrl.branch_ne;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign PCSource    = ctrl.pc_source;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign Excecao     = ctrl.excecao;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo (default build; WAIT_STATE_EN
// adds a FETCH wait-state sequence).
module tb_controle_multiciclo;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] OpCode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite;
    logic       IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst, Excecao;
    logic [1:0] PCSource, ALUSrcB;
    logic [3:0] ALUOp, Estado;

    controle_multiciclo dut (
        .clock       (clock),
        .reset       (reset),
        .OpCode      (OpCode),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .BranchNE    (BranchNE),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .Excecao     (Excecao),
        .Estado      (Estado)
    );

    always #5 clock = ~clock;

    // Output vector layout:
    // {PCWrite,PCWriteCond,BranchNE,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
    //  ALUSrcA,RegWrite,RegDst,PCSource,ALUSrcB,ALUOp,Excecao,Estado}
    logic [23:0] dut_v;
    assign dut_v = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
                    IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst,
                    PCSource, ALUSrcB, ALUOp, Excecao, Estado};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] sb_q[$];

    typedef struct packed {
        logic [5:0]  op;
        logic [3:0]  n;
        logic [19:0] seq;   // state k in seq[4k+:4]
    } vec_t;

    vec_t tab [8];

    // Reference outputs written straight from the per-state table.
    function automatic logic [23:0] model(input logic [3:0] st, input logic [5:0] op,
                                          input logic rst, input logic mr);
        logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, srca, rw, rd, exc;
        logic [1:0] pcs, srcb;
        logic [3:0] aop;
        {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, srca, rw, rd, exc} = '0;
        pcs = 2'b00; srcb = 2'b00; aop = 4'd0;
        case (st)
            4'd0:  begin mrd = 1'b1; irw = mr; pcw = mr; srcb = 2'b01; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin srca = 1'b1; srcb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mwr = 1'b1; iord = 1'b1; end
            4'd6:  begin srca = 1'b1; aop = 4'd2; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin srca = 1'b1; aop = 4'd1; pcs = 2'b01; pcwc = 1'b1;
                         bne = (op == 6'd5); end
            4'd9:  begin pcs = 2'b10; pcw = 1'b1; end
            4'd10: begin srca = 1'b1; srcb = 2'b10; aop = (op == 6'd10) ? 4'd4 : 4'd3; end
            4'd11: rw = 1'b1;
            4'd12: exc = 1'b1;
            default: ;
        endcase
        if (rst) return '0;
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, srca, rw, rd,
                pcs, srcb, aop, exc, st};
    endfunction

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare each queued expectation mid-cycle.
    always @(negedge clock) begin
        if (sb_q.size() > 0) check("scoreboard", dut_v, sb_q.pop_front());
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] st;
        logic [5:0] op;

        tab[0] = '{op: 6'd35, n: 4'd5, seq: {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
        tab[1] = '{op: 6'd43, n: 4'd4, seq: {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
        tab[2] = '{op: 6'd0,  n: 4'd4, seq: {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
        tab[3] = '{op: 6'd4,  n: 4'd3, seq: {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        tab[4] = '{op: 6'd5,  n: 4'd3, seq: {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        tab[5] = '{op: 6'd2,  n: 4'd3, seq: {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}};
        tab[6] = '{op: 6'd8,  n: 4'd4, seq: {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}};
        tab[7] = '{op: 6'd10, n: 4'd4, seq: {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}};

        reset    = 1'b1;
        OpCode   = 6'd0;
        MemReady = 1'b1;
        #2;
        check("reset_outputs_zero", dut_v, '0);
        step();
        reset = 1'b0;
        #1;
        check("first_fetch", dut_v, model(4'd0, 6'd0, 1'b0, 1'b1));

        // Table: one instruction per record; OpCode is scrambled after
        // DECODE so later states must rely on the latched opcode.
        for (int i = 0; i < 8; i++) begin
            op = tab[i].op;
            for (int k = 0; k < int'(tab[i].n); k++) begin
                st = tab[i].seq[4*k +: 4];
                if (k == 0) OpCode = op;
                if (k == 2) OpCode = ~op;
                sb_q.push_back(model(st, op, 1'b0, 1'b1));
                step();
            end
        end

        // Illegal opcode: trap is absorbing regardless of OpCode.
        OpCode = 6'd63;
        sb_q.push_back(model(4'd0, 6'd63, 1'b0, 1'b1));
        step();
        sb_q.push_back(model(4'd1, 6'd63, 1'b0, 1'b1));
        step();
        for (int c = 0; c < 20; c++) begin
            OpCode = 6'($urandom_range(0, 63));
            sb_q.push_back(model(4'd12, 6'd63, 1'b0, 1'b1));
            step();
        end
        reset = 1'b1;
        #1;
        check("illegal_reset_zero", dut_v, '0);
        step();
        reset = 1'b0;
        #1;
        check("illegal_exit_fetch", dut_v, model(4'd0, 6'd0, 1'b0, 1'b1));

        // Reset asserted mid-instruction in EXEC_R.
        OpCode = 6'd0;
        step();
        check("decode_before_reset", dut_v, model(4'd1, 6'd0, 1'b0, 1'b1));
        step();
        check("exec_r_state", dut_v, model(4'd6, 6'd0, 1'b0, 1'b1));
        #1;
        reset = 1'b1;
        #1;
        check("reset_mid_instr", dut_v, '0);
        step();
        check("reset_held", dut_v, '0);
        reset = 1'b0;
        #1;
        check("after_reset_fetch", dut_v, model(4'd0, 6'd0, 1'b0, 1'b1));
        step();

`ifdef WAIT_STATE_EN
        // FETCH held by MemReady low for three cycles.
        sb_q.push_back(model(4'd1, 6'd0, 1'b0, 1'b1));
        step();
        sb_q.push_back(model(4'd6, 6'd0, 1'b0, 1'b1));
        step();
        sb_q.push_back(model(4'd7, 6'd0, 1'b0, 1'b1));
        step();
        MemReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sb_q.push_back(model(4'd0, 6'd0, 1'b0, 1'b0));
            step();
        end
        MemReady = 1'b1;
        sb_q.push_back(model(4'd0, 6'd0, 1'b0, 1'b1));
        step();
        sb_q.push_back(model(4'd1, 6'd0, 1'b0, 1'b1));
        step();
`else
        // Finish the R-format instruction and confirm the next FETCH.
        sb_q.push_back(model(4'd1, 6'd0, 1'b0, 1'b1));
        step();
        sb_q.push_back(model(4'd6, 6'd0, 1'b0, 1'b1));
        step();
        sb_q.push_back(model(4'd7, 6'd0, 1'b0, 1'b1));
        step();
        sb_q.push_back(model(4'd0, 6'd0, 1'b0, 1'b1));
        step();
`endif

        @(negedge clock);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multi-cycle sequencer for the MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back, driving the shared-memory, ALU and register-file control lines one state per clock. It replaces per-opcode single-cycle decoding wherever the datapath shares one memory and one ALU across cycles. An optional memory-ready handshake stretches the memory states.

## Interface
- No parameters.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- OpCode  in  6  instruction bits [31:26] from the instruction register.
- MemReady  in  1  memory access complete. Used only with `WAIT_STATE_EN`.
- PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls.
- PCSource  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUSrcB  out  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- ALUOp  out  4  ALU operation: 0 = add, 1 = sub, 2 = R-format funct, 3 = addi, 4 = slti.
- Excecao  out  1  illegal opcode trap.
- Estado  out  4  current state, for debug.

## Operation
- Opcode latching:
  - Opcode is registered into `op_q` on the DECODE→next transition.
  - Every later state uses `op_q`, never the live `OpCode`.
- States and transitions (encoding in parentheses):
  - FETCH (0) → DECODE.
  - DECODE (1) branches on the opcode:
    - 35 or 43 → MEM_ADDR.
    - 0 → EXEC_R.
    - 4 or 5 → BRANCH.
    - 2 → JUMP.
    - 8 or 10 → EXEC_I.
    - anything else → ILLEGAL.
  - MEM_ADDR (2): lw → MEM_RD; sw → MEM_WR.
  - MEM_RD (3) → MEM_WB (4) → FETCH.
  - MEM_WR (5) → FETCH.
  - EXEC_R (6) → R_WB (7) → FETCH.
  - BRANCH (8) → FETCH.
  - JUMP (9) → FETCH.
  - EXEC_I (10) → I_WB (11) → FETCH.
  - ILLEGAL (12) is absorbing; only reset leaves it.
- Outputs per state. Any output not listed is 0.
  - FETCH: MemRead, IRWrite, PCWrite = 1; IorD = 0; ALUSrcA = 0; ALUSrcB = 01; ALUOp = 0; PCSource = 00.
  - DECODE: ALUSrcA = 0; ALUSrcB = 11; ALUOp = 0.
  - MEM_ADDR: ALUSrcA = 1; ALUSrcB = 10; ALUOp = 0.
  - MEM_RD: MemRead = 1; IorD = 1.
  - MEM_WB: RegWrite = 1; MemtoReg = 1; RegDst = 0.
  - MEM_WR: MemWrite = 1; IorD = 1.
  - EXEC_R: ALUSrcA = 1; ALUSrcB = 00; ALUOp = 2.
  - R_WB: RegDst = 1; RegWrite = 1.
  - BRANCH: ALUSrcA = 1; ALUSrcB = 00; ALUOp = 1; PCSource = 01; PCWriteCond = 1; BranchNE = (op_q == 5).
  - JUMP: PCSource = 10; PCWrite = 1.
  - EXEC_I: ALUSrcA = 1; ALUSrcB = 10; ALUOp = 3 for addi, 4 for slti.
  - I_WB: RegWrite = 1; RegDst = 0; MemtoReg = 0.
  - ILLEGAL: Excecao = 1.
- Reset:
  - While `reset` is high, every output is forced to 0 combinationally, including Estado.
  - State goes to FETCH and `op_q` to 0 immediately, mid-instruction included.
  - Releasing reset starts a fresh FETCH.

## Timing
- All state changes happen on the rising edge of `clock`. Outputs are a decode of the state (plus `MemReady` when gated), so they settle within the same cycle.
- Clocks per instruction with no wait states:
  - R-format, sw, addi, slti: 4.
  - lw: 5.
  - beq, bne, j: 3.
- Branch resolution is the datapath's job: it qualifies PCWriteCond with Zero XOR BranchNE.
- No bubbles: FETCH of the next instruction follows immediately after the last state.

## Configuration
- `WAIT_STATE_EN` defined:
  - FETCH, MEM_RD and MEM_WR hold until `MemReady` = 1. MemRead/MemWrite/IorD stay asserted throughout.
  - In FETCH, IRWrite and PCWrite are asserted only in the cycle where `MemReady` = 1.
  - `MemReady` is ignored in all other states.
- `WAIT_STATE_EN` undefined: `MemReady` is unused, and every memory state lasts exactly one cycle.

## Structure
- Shared package holds:
  - state encodings;
  - opcode constants (R = 0, J = 2, BEQ = 4, BNE = 5, ADDI = 8, SLTI = 10, LW = 35, SW = 43);
  - ALUOp codes 0–4;
  - PCSource and ALUSrcB codes.
- Sub-module `controle_saidas`: purely combinational decode from state (and `op_q`) to outputs.
- The top level keeps the state register, `op_q` and the next-state logic.

## Test plan
- Reset during EXEC_R (Estado = 6) → all outputs 0 immediately; after release Estado = 0 and MemRead = 1.
- OpCode = 35, no wait states → Estado sequence 0, 1, 2, 3, 4, 0; MemtoReg = 1 and RegWrite = 1 only in state 4.
- OpCode = 5 → Estado 0, 1, 8; in state 8, BranchNE = 1, PCWriteCond = 1, ALUOp = 1, PCSource = 01.
- OpCode = 10 → state 10 with ALUOp = 4 and ALUSrcB = 10, then state 11 with RegWrite = 1 and RegDst = 0.
- OpCode = 63 → ILLEGAL (12) with Excecao = 1, held for 20 cycles until reset.
- `WAIT_STATE_EN`, MemReady low for 3 cycles in FETCH → Estado stays 0 for 4 cycles; IRWrite and PCWrite pulse once, in the 4th cycle.
